// File: rtl/sqrt_vec_sequencer_pkg.sv
`default_nettype none
// vector_types: fp16 types, constants and the special-case resolver shared by the sqrt front-end.
// Rev 1.0
package vector_types;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_QNAN  = 16'h7E00;
  localparam fp16_t FP16_PINF  = 16'h7C00;
  localparam fp16_t FP16_NZERO = 16'h8000;

  typedef struct packed {
    logic  hit;
    fp16_t val;
  } resolve_t;

  // hit=1 means the element never needs the sqrt unit; val is its final result.
  function automatic resolve_t resolve_local(input fp16_t x, input logic active);
    resolve_t r;
    r.hit = 1'b1;
    r.val = x;
    if (!active) begin
      r.val = x;
    end else if ((x[14:10] == 5'h1F) && (x[9:0] != 10'h000)) begin
      r.val = FP16_QNAN;
    end else if (x[15] && (x != FP16_NZERO)) begin
      r.val = FP16_QNAN;
    end else if (x == FP16_PINF) begin
      r.val = FP16_PINF;
    end else if (x[14:10] == 5'h00) begin
      r.val = {x[15], 15'b0};
    end else begin
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: small synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
// Rev 1.0
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i && (cnt_q != FULL_CNT);
  assign w_pop   = pop_i && (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
      if (w_pop)  rd_q <= (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_vec_sequencer.sv
`default_nettype none
// sqrt_vec_sequencer: streams eligible fp16 lanes of a vector into a scalar sqrt unit and reassembles results.
// Rev 1.0
module sqrt_vec_sequencer
  import vector_types::*;
#(
  parameter int LANES     = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_vec,
  input  logic [LANES-1:0]      in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_vec,
  output logic                  sqrt_valid,
  output logic [15:0]           sqrt_operand,
  input  logic [15:0]           sqrt_result,
  input  logic                  sqrt_result_valid
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(TAG_DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [16*LANES-1:0] vec_q;
  logic [LANES-1:0]    mask_q;
  logic [LW-1:0]       lane_q;
  logic [16*LANES-1:0] res_q;

  fp16_t          w_x;
  resolve_t       w_res;
  logic           w_in_issue;
  logic           w_issue;
  logic           w_adv;
  logic           w_pop;
  logic [LW-1:0]  w_tag;
  logic           w_empty;
  logic [CW-1:0]  w_in_flight;

  assign w_x        = vec_q[{lane_q, 4'b0000} +: 16];
  assign w_res      = resolve_local(w_x, mask_q[lane_q]);
  assign w_in_issue = (state_q == S_ISSUE);
  assign w_issue    = w_in_issue && !w_res.hit && (w_in_flight != FULL_CNT);
  assign w_adv      = w_in_issue && (w_res.hit || w_issue);
  assign w_pop      = sqrt_result_valid && !w_empty;

  // Issue decode is purely from registered state, so no input reaches the sqrt unit combinationally.
  assign sqrt_valid   = w_issue;
  assign sqrt_operand = w_issue ? w_x : 16'h0000;
  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_vec      = res_q;

  sync_fifo #(
    .WIDTH (LW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_issue),
    .data_i  (lane_q),
    .pop_i   (sqrt_result_valid),
    .data_o  (w_tag),
    .empty_o (w_empty),
    .count_o (w_in_flight)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      mask_q  <= '0;
      lane_q  <= '0;
      res_q   <= '0;
    end else begin
      if (w_pop) res_q[{w_tag, 4'b0000} +: 16] <= sqrt_result;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            vec_q   <= in_vec;
            mask_q  <= in_mask;
            lane_q  <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_res.hit) res_q[{lane_q, 4'b0000} +: 16] <= w_res.val;
          if (w_adv) begin
            lane_q <= lane_q + 1'b1;
            if (lane_q == LAST_LANE) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_in_flight == '0) state_q <= S_DONE;
        end
        default: begin
          if (out_ready) state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_vec_sequencer.sv
`default_nettype none
// Directed bench for sqrt_vec_sequencer using latency-6 "operand+1" sqrt stubs.
module tb_sqrt_vec_sequencer;

  localparam int LANES = 16;
  localparam int L     = 6;
  localparam int VW    = 16 * LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: TAG_DEPTH=8
  logic            a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_sv, a_srv;
  logic [VW-1:0]   a_in_vec = '0, a_out_vec;
  logic [LANES-1:0] a_in_mask = '0;
  logic [15:0]     a_sop, a_sres;
  // Instance B: TAG_DEPTH=2
  logic            b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_sv, b_srv;
  logic [VW-1:0]   b_in_vec = '0, b_out_vec;
  logic [LANES-1:0] b_in_mask = '0;
  logic [15:0]     b_sop, b_sres;

  sqrt_vec_sequencer #(.LANES(LANES), .TAG_DEPTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .in_mask(a_in_mask), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_vec(a_out_vec),
    .sqrt_valid(a_sv), .sqrt_operand(a_sop), .sqrt_result(a_sres), .sqrt_result_valid(a_srv));

  sqrt_vec_sequencer #(.LANES(LANES), .TAG_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .in_mask(b_in_mask), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
    .sqrt_valid(b_sv), .sqrt_operand(b_sop), .sqrt_result(b_sres), .sqrt_result_valid(b_srv));

  // Stub sqrt pipelines; deliberately not cleared by rst so stale returns reach the DUT.
  logic [L-1:0] a_pv = '0, b_pv = '0;
  logic [15:0]  a_pd [L];
  logic [15:0]  b_pd [L];
  initial for (int i = 0; i < L; i++) begin a_pd[i] = '0; b_pd[i] = '0; end
  always @(posedge clk) begin
    a_pv <= {a_pv[L-2:0], a_sv};
    b_pv <= {b_pv[L-2:0], b_sv};
    a_pd[0] <= a_sop + 16'h0001;
    b_pd[0] <= b_sop + 16'h0001;
    for (int i = 1; i < L; i++) begin
      a_pd[i] <= a_pd[i-1];
      b_pd[i] <= b_pd[i-1];
    end
  end
  assign a_srv  = a_pv[L-1];
  assign a_sres = a_pd[L-1];
  assign b_srv  = b_pv[L-1];
  assign b_sres = b_pd[L-1];

  int a_sv_cnt = 0;
  int b_infl = 0, b_peak = 0, b_viol = 0;
  always @(negedge clk) begin
    if (a_sv) a_sv_cnt++;
    if (b_sv && b_infl >= 2) b_viol++;
  end
  always @(posedge clk) begin
    b_infl <= b_infl + (b_sv ? 1 : 0) - ((b_srv && b_infl > 0) ? 1 : 0);
    if (b_infl > b_peak) b_peak <= b_infl;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [VW-1:0] mkvec(input logic [15:0] base, input logic [15:0] step);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = base + step * 16'(i);
    return v;
  endfunction

  task automatic a_send(input logic [VW-1:0] v, input logic [LANES-1:0] m, output int waits);
    waits = 0;
    @(negedge clk);
    a_in_vec = v; a_in_mask = m; a_in_valid = 1'b1;
    while (!a_in_ready && waits < 100) begin @(negedge clk); waits++; end
    @(posedge clk); #1 a_in_valid = 1'b0;
  endtask

  // Returns the cycle number (handshake = cycle 0) in which out_valid is first seen.
  task automatic a_wait_out(output int n);
    n = 1;
    @(negedge clk);
    while (!a_out_valid && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic a_take();
    @(negedge clk); a_out_ready = 1'b1;
    @(posedge clk); #1 a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_out_vec !== '0) begin bad++; $display("FAIL rst_out_vec: got %h want 0", a_out_vec); end
    total++; if (a_sv !== 1'b0) begin bad++; $display("FAIL rst_sqrt_valid: got %b want 0", a_sv); end
    total++; if (a_sop !== 16'h0000) begin bad++; $display("FAIL rst_sqrt_operand: got %h want 0000", a_sop); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rst_b_in_ready: got %b want 1", b_in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_all_active();
    int w, n;
    a_send(mkvec(16'h4400, 16'h1), 16'hFFFF, w);
    a_wait_out(n);
    total++; if (n !== 24) begin bad++; $display("FAIL all_latency: got %0d want 24", n); end
    total++; if (a_out_vec !== mkvec(16'h4401, 16'h1)) begin bad++; $display("FAIL all_vec: got %h want %h", a_out_vec, mkvec(16'h4401, 16'h1)); end
    a_take();
    @(negedge clk);
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL all_in_ready_after: got %b want 1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL all_out_valid_after: got %b want 0", a_out_valid); end
  endtask

  task automatic test_special();
    int w, n;
    logic [VW-1:0] v, e;
    v = mkvec(16'h3C00, 16'h0);
    e = mkvec(16'h3C01, 16'h0);
    v[15:0] = 16'hFC01; v[31:16] = 16'hBC00; v[47:32] = 16'h7C00; v[63:48] = 16'h0001; v[79:64] = 16'h8000;
    e[15:0] = 16'h7E00; e[31:16] = 16'h7E00; e[47:32] = 16'h7C00; e[63:48] = 16'h0000; e[79:64] = 16'h8000;
    a_send(v, 16'hFFFF, w);
    a_wait_out(n);
    total++; if (n !== 24) begin bad++; $display("FAIL special_latency: got %0d want 24", n); end
    total++; if (a_out_vec !== e) begin bad++; $display("FAIL special_vec: got %h want %h", a_out_vec, e); end
    a_take();
  endtask

  task automatic test_masked();
    int w, n, c0;
    c0 = a_sv_cnt;
    a_send(mkvec(16'hC000, 16'h1), 16'h0000, w);
    a_wait_out(n);
    total++; if (n !== 18) begin bad++; $display("FAIL masked_latency: got %0d want 18", n); end
    total++; if (a_out_vec !== mkvec(16'hC000, 16'h1)) begin bad++; $display("FAIL masked_vec: got %h want %h", a_out_vec, mkvec(16'hC000, 16'h1)); end
    total++; if (a_sv_cnt !== c0) begin bad++; $display("FAIL masked_sqrt_issues: got %0d want 0", a_sv_cnt - c0); end
    a_take();
  endtask

  task automatic test_tag_depth2();
    int n;
    @(negedge clk);
    b_in_vec = mkvec(16'h4800, 16'h1); b_in_mask = 16'hFFFF; b_in_valid = 1'b1;
    @(posedge clk); #1 b_in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!b_out_valid && n < 500) begin @(negedge clk); n++; end
    total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL tag2_timeout: out_valid got %b want 1", b_out_valid); end
    total++; if (b_out_vec !== mkvec(16'h4801, 16'h1)) begin bad++; $display("FAIL tag2_vec: got %h want %h", b_out_vec, mkvec(16'h4801, 16'h1)); end
    total++; if (b_viol !== 0) begin bad++; $display("FAIL tag2_issue_when_full: got %0d want 0", b_viol); end
    total++; if (b_peak !== 2) begin bad++; $display("FAIL tag2_peak_in_flight: got %0d want 2", b_peak); end
    @(negedge clk); b_out_ready = 1'b1;
    @(posedge clk); #1 b_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int w, n;
    logic [VW-1:0] e1, v2, e2;
    e1 = mkvec(16'h5001, 16'h10);
    v2 = mkvec(16'h3800, 16'h1);
    e2 = v2;
    for (int i = 0; i < 8; i++) e2[16*i +: 16] = v2[16*i +: 16] + 16'h1;
    a_send(mkvec(16'h5000, 16'h10), 16'hFFFF, w);
    a_wait_out(n);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (a_out_vec !== e1) begin bad++; $display("FAIL bp_vec_stable[%0d]: got %h want %h", k, a_out_vec, e1); end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, a_in_ready); end
      total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, a_out_valid); end
    end
    @(negedge clk);
    a_out_ready = 1'b1; a_in_vec = v2; a_in_mask = 16'h00FF; a_in_valid = 1'b1;
    @(posedge clk); #1 a_out_ready = 1'b0;
    @(negedge clk);
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_second_accept: in_ready got %b want 1", a_in_ready); end
    @(posedge clk); #1 a_in_valid = 1'b0;
    a_wait_out(n);
    total++; if (n !== 18) begin bad++; $display("FAIL bp_second_latency: got %0d want 18", n); end
    total++; if (a_out_vec !== e2) begin bad++; $display("FAIL bp_second_vec: got %h want %h", a_out_vec, e2); end
    a_take();
  endtask

  task automatic test_reset_mid();
    int w, n;
    a_send(mkvec(16'h4400, 16'h1), 16'hFFFF, w);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_out_vec !== '0) begin bad++; $display("FAIL midrst_out_vec: got %h want 0", a_out_vec); end
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_out_vec !== '0) begin bad++; $display("FAIL midrst_stale_vec: got %h want 0", a_out_vec); end
    a_send(mkvec(16'h4600, 16'h1), 16'hFFFF, w);
    a_wait_out(n);
    total++; if (n !== 24) begin bad++; $display("FAIL midrst_next_latency: got %0d want 24", n); end
    total++; if (a_out_vec !== mkvec(16'h4601, 16'h1)) begin bad++; $display("FAIL midrst_next_vec: got %h want %h", a_out_vec, mkvec(16'h4601, 16'h1)); end
    a_take();
  endtask

  initial begin
    test_reset();
    test_all_active();
    test_special();
    test_masked();
    test_tag_depth2();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sqrt_vec_sequencer.md
# sqrt_vec_sequencer

Front-end sequencer for the fp16 square-root pipeline. It accepts a whole vector-register operand of LANES fp16 elements over a ready/valid handshake and streams eligible elements, one per cycle, into the scalar sqrt unit. It resolves special-case elements locally without using the unit, and reassembles in-order sqrt results into their original lanes. It then presents the complete result vector downstream over a ready/valid handshake.

## Interface
- LANES, 16, elements per vector (power of two, ≥2)
- TAG_DEPTH, 8, max sqrt operations in flight; must be ≥ sqrt unit latency L + 1
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand vector valid
- in_ready  out  1  sequencer can accept a vector
- in_vec  in  16*LANES  operand; lane i = bits [16i+15:16i]
- in_mask  in  LANES  1 = lane active
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts
- out_vec  out  16*LANES  result vector
- sqrt_valid  out  1  drives sqrt unit valid_data_in
- sqrt_operand  out  16  drives sqrt unit input_val
- sqrt_result  in  16  sqrt unit output_val
- sqrt_result_valid  in  1  sqrt unit valid_data_out

## Operation
- FSM IDLE → ISSUE → DRAIN → DONE → IDLE; one vector resident at a time.
- IDLE: in_ready=1. in_valid&in_ready latches in_vec/in_mask, lane_idx←0, → ISSUE.
- ISSUE, element x = lane lane_idx, checked in priority order:
  - mask=0: result ← x unchanged.
  - exp=31, mant≠0: result ← 16'h7E00.
  - sign=1, x≠16'h8000: result ← 16'h7E00.
  - x=16'h7C00: result ← 16'h7C00.
  - exp=0 (zero/subnormal): result ← {sign,15'b0}.
  - Otherwise, if in_flight<TAG_DEPTH: sqrt_valid=1, sqrt_operand=x, push lane_idx to tag FIFO. If in_flight=TAG_DEPTH: stall, lane_idx holds, sqrt_valid=0.
  - lane_idx increments when the lane resolves or issues. After lane LANES-1 resolves → DRAIN.
- Any state: sqrt_result_valid pops the tag FIFO and writes sqrt_result to that lane of the result buffer. With the FIFO empty, the result is dropped.
- A local resolve and a returned result in the same cycle write different lanes; both take effect.
- in_flight: +1 on issue, -1 on return, unchanged on simultaneous issue and return.
- DRAIN: → DONE when in_flight=0.
- DONE: out_valid=1, out_vec=result buffer (stable). out_ready → IDLE.
- sqrt_valid/sqrt_operand derive only from registered state; no in_* → sqrt_* combinational path.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_vec=0, sqrt_valid=0, sqrt_operand=0, in_flight=0, FIFO empty.
- Handshake in cycle 0 → ISSUE in cycles 1..LANES with no stall.
- Worst-case issue: last active lane issued in cycle LANES, returns in cycle LANES+L, DRAIN sees in_flight=0 in LANES+L+1, out_valid first high in cycle LANES+L+2.
- All lanes resolved locally: out_valid first high in cycle LANES+2.
- Stall cycles add one-for-one.
- out_valid holds until out_ready. in_ready=1 again the cycle after the output handshake.
- RST mid-operation clears all state; in-flight sqrt returns that arrive afterwards are dropped (empty FIFO). The sqrt unit shares the same reset net.

## Structure
- Shared package vector_types:
  - typedef fp16_t (logic [15:0])
  - constants FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00, FP16_NZERO=16'h8000
- FSM state enum stays local to the module.
- One sub-module: sync_fifo (WIDTH=$clog2(LANES), DEPTH=TAG_DEPTH) holding lane tags. in_flight equals the FIFO count.

## Test plan
Bench uses a stub sqrt with latency L=6 that returns operand+1, so ordering is checked exactly.
- All lanes active, lane i = 16'h4400+i → out_vec lane i = 16'h4401+i; out_valid first in cycle 16+6+2=24.
- Lanes 0..4 = {16'hFC01, 16'hBC00, 16'h7C00, 16'h0001, 16'h8000}, rest 16'h3C00 → {7E00, 7E00, 7C00, 0000, 8000}, rest 3C01.
- in_mask=16'h0000, any in_vec → out_vec==in_vec; out_valid in cycle 18; sqrt_valid never high.
- TAG_DEPTH=2, L=6, all lanes active → sqrt_valid never high while in_flight=2; results are correct and in lane order.
- out_ready held 0 for 10 cycles in DONE → out_vec stable, in_ready=0. Second vector is accepted the cycle after out_ready=1.
- RST asserted at cycle 5 of ISSUE → in_ready=1, out_valid=0 immediately. Stale sqrt_result_valid pulses are ignored; the next vector's results are correct.
